// File: rtl/uart_pkg.sv
// Shared constants and the reset-divisor helper for the UART baud generator.
// The divisor is expressed in units of 1/2^frac_w clock per oversample tick.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int FRAC_W_DEF     = 4;
    localparam int MIN_DIV        = 2;

    // round(clk_freq * 2^frac_w / (baud * oversample)), evaluated in 64 bits
    function automatic longint calc_def_div(
        input longint clk_freq,
        input longint baud,
        input longint oversample,
        input int     frac_w
    );
        longint num;
        longint den;
        num = clk_freq << frac_w;
        den = baud * oversample;
        return (num + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider: emits tick_os every div_int (+1 on accumulator carry)
// clocks, with shadow/pending divisor registers so reloads never distort a period.
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick_os,
    output logic              cfg_err
);

    localparam longint DEF = calc_def_div(longint'(CLK_FREQ), longint'(BAUD),
                                          longint'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  int_sh;
    logic [DIV_W-1:0]  int_pend;
    logic [DIV_W-1:0]  ld_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] frac_sh;
    logic [FRAC_W-1:0] frac_pend;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W:0]    period_last;
    logic              carry;
    logic              pend_vld;
    logic              ld_clamp;
    logic              restart;
    logic              boundary;

    assign ld_clamp    = div_int < DIV_W'(MIN_DIV);
    assign ld_int      = ld_clamp ? DIV_W'(MIN_DIV) : div_int;
    assign acc_sum     = {1'b0, acc} + {1'b0, frac_sh};
    assign period_last = {1'b0, int_sh} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
    assign restart     = !enable || sync;
    assign tick_os     = !restart && ({1'b0, cnt} == period_last);
    // Any point where a new period starts is safe for a divisor swap.
    assign boundary    = restart || tick_os;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else if (tick_os) begin
            cnt          <= '0;
            {carry, acc} <= acc_sum;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_sh    <= DEF_INT;
            frac_sh   <= DEF_FRAC;
            int_pend  <= '0;
            frac_pend <= '0;
            pend_vld  <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (load) begin
            cfg_err <= ld_clamp;
            if (boundary) begin
                int_sh   <= ld_int;
                frac_sh  <= div_frac;
                pend_vld <= 1'b0;
            end else begin
                int_pend  <= ld_int;
                frac_pend <= div_frac;
                pend_vld  <= 1'b1;
            end
        end else if (pend_vld && boundary) begin
            int_sh   <= int_pend;
            frac_sh  <= frac_pend;
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// UART baud generator: fractional oversample divider plus the per-bit counter
// that decodes mid-bit and end-of-bit ticks.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              sync,
    output logic              tick_os,
    output logic              tick_mid,
    output logic              tick_bit,
    output logic              cfg_err
);

    localparam int BW = $clog2(OVERSAMPLE);
    localparam logic [BW-1:0] BIT_LAST = BW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_MID  = BW'(OVERSAMPLE / 2 - 1);

    logic [BW-1:0] bitcnt;

    uart_frac_divider #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sync     (sync),
        .load     (load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .tick_os  (tick_os),
        .cfg_err  (cfg_err)
    );

    // Bit phase restarts together with the oversample phase on sync.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt <= '0;
        end else if (!enable || sync) begin
            bitcnt <= '0;
        end else if (tick_os) begin
            bitcnt <= (bitcnt == BIT_LAST) ? '0 : bitcnt + BW'(1);
        end
    end

    assign tick_bit = tick_os && (bitcnt == BIT_LAST);
    assign tick_mid = tick_os && (bitcnt == BIT_MID);

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: a tick-schedule model checked every cycle plus
// directed scenarios with hand-computed tick times.
module tb_uart_baud_gen_frac;
    import uart_pkg::*;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV_W    = 16;
    localparam int FRAC_W   = 4;
    localparam int M        = 1 << FRAC_W;
    localparam longint DEF  = calc_def_div(longint'(CLK_FREQ), longint'(BAUD), longint'(OS), FRAC_W);
    localparam int BUDGET   = 1000;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              sync;
    logic              tick_os;
    logic              tick_mid;
    logic              tick_bit;
    logic              cfg_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    uart_baud_gen_frac #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .div_int(div_int),
        .div_frac(div_frac), .sync(sync), .tick_os(tick_os), .tick_mid(tick_mid),
        .tick_bit(tick_bit), .cfg_err(cfg_err)
    );

    // clock / cycle index
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: divisor in use, time into the current period, fractional residue
    // (sum of fractions modulo M) and the number of ticks since the last restart.
    int m_int, m_frac, p_int, p_frac, m_pend, m_cfg;
    int m_elapsed, m_extra, m_res, m_nticks;

    task automatic model_reset();
        m_int = int'(DEF / M); m_frac = int'(DEF % M);
        p_int = 0; p_frac = 0; m_pend = 0; m_cfg = 0;
        m_elapsed = 0; m_extra = 0; m_res = 0; m_nticks = 0;
    endtask

    always @(negedge clk) begin : compare
        int tot, clamped;
        bit e_os, e_mid, e_bit, bnd;
        if (!reset) begin
            model_reset();
            check("rst_os", tick_os, 0);
            check("rst_mid", tick_mid, 0);
            check("rst_bit", tick_bit, 0);
            check("rst_cfg", cfg_err, 0);
        end else begin
            e_os  = enable && !sync && (m_elapsed + 1 == m_int + m_extra);
            e_mid = e_os && (m_nticks % OS == OS / 2 - 1);
            e_bit = e_os && (m_nticks % OS == OS - 1);
            check("os", tick_os, e_os);
            check("mid", tick_mid, e_mid);
            check("bit", tick_bit, e_bit);
            check("cfg", cfg_err, m_cfg);
            if (!enable || sync) begin
                m_elapsed = 0; m_extra = 0; m_res = 0; m_nticks = 0;
            end else if (e_os) begin
                tot = m_res + m_frac;
                m_extra = tot / M;
                m_res = tot % M;
                m_elapsed = 0;
                m_nticks++;
            end else begin
                m_elapsed++;
            end
            bnd = !enable || sync || e_os;
            if (load) begin
                clamped = (int'(div_int) < 2) ? 2 : int'(div_int);
                m_cfg = (int'(div_int) < 2);
                if (bnd) begin
                    m_int = clamped; m_frac = int'(div_frac); m_pend = 0;
                end else begin
                    p_int = clamped; p_frac = int'(div_frac); m_pend = 1;
                end
            end else if (m_pend != 0 && bnd) begin
                m_int = p_int; m_frac = p_frac; m_pend = 0;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int di, input int df);
        load = 1'b1;
        div_int = DIV_W'(di);
        div_frac = FRAC_W'(df);
        step();
        load = 1'b0;
    endtask

    task automatic wait_os(output int t);
        t = -1;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (tick_os === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("wait_os_timeout", 0, 1);
    endtask

    int t_en, t, t2, t3, t4, sum;
    int tk[18];
    int exp3[7] = '{4, 4, 5, 4, 5, 4, 5};

    initial begin
        reset = 1'b0; enable = 1'b0; load = 1'b0; sync = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) @(posedge clk);
        #1;

        // default divisor 325 + 8/16
        reset = 1'b1; enable = 1'b1; t_en = cyc;
        for (int k = 1; k <= 17; k++) begin
            wait_os(tk[k]);
            check("t1_mid", tick_mid, k == 8);
            check("t1_bit", tick_bit, k == 16);
        end
        check("t1_first", tk[1] - t_en + 1, 325);
        check("t1_i2", tk[2] - tk[1], 325);
        check("t1_i3", tk[3] - tk[2], 326);
        check("t1_i4", tk[4] - tk[3], 325);
        check("t1_span16", tk[17] - tk[1], 5208);

        // divisor 4 loaded while disabled
        step();
        enable = 1'b0;
        pulse_load(4, 0);
        enable = 1'b1; t_en = cyc;
        for (int k = 1; k <= 16; k++) begin
            wait_os(t);
            check("t2_time", t - t_en + 1, 4 * k);
            check("t2_mid", tick_mid, k == 8);
            check("t2_bit", tick_bit, k == 16);
        end

        // divisor 4 + 8/16
        step();
        enable = 1'b0;
        pulse_load(4, 8);
        enable = 1'b1; t_en = cyc;
        for (int k = 1; k <= 17; k++) wait_os(tk[k]);
        check("t3_i1", tk[1] - t_en + 1, exp3[0]);
        for (int k = 2; k <= 7; k++) check("t3_ik", tk[k] - tk[k-1], exp3[k-1]);
        check("t3_span16", tk[17] - tk[1], 72);

        // reload mid-period and coincident with a tick
        step();
        enable = 1'b0;
        pulse_load(4, 0);
        enable = 1'b1;
        wait_os(t);
        step(); step();
        pulse_load(6, 0);
        wait_os(t2);
        check("t4_keep4", t2 - t, 4);
        wait_os(t3);
        check("t4_next6", t3 - t2, 6);
        repeat (6) step();
        load = 1'b1; div_int = DIV_W'(4); div_frac = '0;
        wait_os(t4);
        check("t4_coinc_tick", t4 - t3, 6);
        step();
        load = 1'b0;
        wait_os(t);
        check("t4_coinc_next4", t - t4, 4);

        // sync in the cycle a tick would fire
        repeat (4) step();
        sync = 1'b1;
        @(negedge clk);
        check("t5_sync_os", tick_os, 0);
        step();
        sync = 1'b0;
        wait_os(t2);
        check("t5_after_sync", t2 - (t + 4), 4);
        check("t5_mid_k1", tick_mid, 0);
        for (int k = 2; k <= 8; k++) begin
            wait_os(t3);
            check("t5_mid", tick_mid, k == 8);
        end

        // clamp, cfg_err, async reset
        step();
        enable = 1'b0;
        pulse_load(1, 0);
        @(negedge clk);
        check("t6_cfg_set", cfg_err, 1);
        step();
        enable = 1'b1; t_en = cyc;
        wait_os(t);
        check("t6_first2", t - t_en + 1, 2);
        wait_os(t2);
        check("t6_per2", t2 - t, 2);
        step();
        pulse_load(3, 0);
        @(negedge clk);
        check("t6_cfg_clr", cfg_err, 0);
        step();
        pulse_load(0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_os", tick_os, 0);
        check("t6_async_mid", tick_mid, 0);
        check("t6_async_bit", tick_bit, 0);
        check("t6_async_cfg", cfg_err, 0);
        step(); step();
        reset = 1'b1; t_en = cyc;
        wait_os(t);
        check("t6_def_first", t - t_en + 1, 325);
        wait_os(t2);
        check("t6_def_per", t2 - t, 325);

        // randomized traffic, checked cycle by cycle against the model
        step();
        for (int i = 0; i < 4000; i++) begin
            enable   = ($urandom_range(0, 99) < 97);
            load     = ($urandom_range(0, 99) < 5);
            sync     = ($urandom_range(0, 99) < 2);
            div_int  = DIV_W'($urandom_range(0, 9));
            div_frac = FRAC_W'($urandom_range(0, M - 1));
            step();
        end
        enable = 1'b1; load = 1'b0; sync = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
